// File: rtl/filter_gpu_pkg.sv
// Shared types for the kernel-select controller: kernel codes, FSM states,
// button slot indices and the kernel priority encoder.
package filter_gpu_pkg;

  typedef enum logic [1:0] {
    K1 = 2'b00,
    K2 = 2'b01,
    K3 = 2'b10
  } kernel_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_DRAIN   = 2'b01,
    S_RESTART = 2'b10
  } state_t;

  localparam int NUM_BTN = 4;
  localparam int BTN_K1  = 0;
  localparam int BTN_K2  = 1;
  localparam int BTN_K3  = 2;
  localparam int BTN_ID  = 3;

  // kernel1 wins over kernel2 wins over kernel3; caller guarantees kp != 0
  function automatic kernel_t prio_kernel(input logic [2:0] kp);
    if (kp[0]) return K1;
    if (kp[1]) return K2;
    return K3;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stable-count debouncer and a one-cycle
// press pulse on the debounced falling edge (releases are silent).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // any cycle where the input agrees with the level restarts the count
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          press_q <= ~sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/kernel_select_ctrl.sv
// Kernel/identity selection for the filter processor: changes are deferred
// to the end of the displayed frame, then the processor is held in reset.
module kernel_select_ctrl
  import filter_gpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_CYCLES      = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       kernel1_n,
  input  logic       kernel2_n,
  input  logic       kernel3_n,
  input  logic       identity_n,
  input  logic       frame_done,
  output logic [1:0] kernel,
  output logic       identity_en,
  output logic       proc_rst,
  output logic       sel_valid,
  output logic       busy
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_n, press;

  assign btn_n = {identity_n, kernel3_n, kernel2_n, kernel1_n};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk_i   (CLK),
        .rst_i   (reset),
        .btn_n_i (btn_n[i]),
        .press_o (press[i])
      );
    end
  endgenerate

  state_t        state_q, state_d;
  kernel_t       kernel_q, kernel_d, pk_q, pk_d, kcode;
  logic          ident_q, ident_d, pid_q, pid_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          proc_rst_q, proc_rst_d, sel_valid_q, sel_valid_d, busy_q, busy_d;
  logic          kpress;

  assign kpress = |press[BTN_K3:BTN_K1];
  assign kcode  = prio_kernel(press[BTN_K3:BTN_K1]);

  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    ident_d     = ident_q;
    pk_d        = pk_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    sel_valid_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if ((kpress && kcode != kernel_q) || press[BTN_ID]) begin
          pk_d    = kpress ? kcode : kernel_q;
          pid_d   = press[BTN_ID] ? ~ident_q : ident_q;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (kpress)        pk_d  = kcode;
        if (press[BTN_ID]) pid_d = ~pid_q;
        // restart even when the pending selection equals the current one
        if (frame_done) begin
          kernel_d = pk_d;
          ident_d  = pid_d;
          cnt_d    = '0;
          state_d  = S_RESTART;
        end
      end
      S_RESTART: begin
        if (cnt_q == RST_LAST) begin
          cnt_d       = '0;
          sel_valid_d = 1'b1;
          state_d     = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_RESTART;
    endcase
    proc_rst_d = (state_d == S_RESTART);
    busy_d     = (state_d != S_RUN);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESTART;
      kernel_q    <= K1;
      ident_q     <= 1'b0;
      pk_q        <= K1;
      pid_q       <= 1'b0;
      cnt_q       <= '0;
      proc_rst_q  <= 1'b1;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      kernel_q    <= kernel_d;
      ident_q     <= ident_d;
      pk_q        <= pk_d;
      pid_q       <= pid_d;
      cnt_q       <= cnt_d;
      proc_rst_q  <= proc_rst_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign kernel      = kernel_q;
  assign identity_en = ident_q;
  assign proc_rst    = proc_rst_q;
  assign sel_valid   = sel_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_kernel_select_ctrl.sv
// Scoreboard bench: each expected {identity_en, kernel} is queued when a
// selection is set up and checked when sel_valid fires.
module tb_kernel_select_ctrl;

  logic       CLK = 1'b0, reset = 1'b1;
  logic       k1n = 1'b1, k2n = 1'b1, k3n = 1'b1, idn = 1'b1, frame_done = 1'b0;
  logic [1:0] kernel;
  logic       identity_en, proc_rst, sel_valid, busy;

  int         n_chk = 0, n_err = 0, sv_cnt = 0, prst_len = 0, s = 0, seen = 0;
  logic [2:0] sb[$];
  logic [2:0] e;

  always #5 CLK = ~CLK;

  kernel_select_ctrl #(.DEBOUNCE_CYCLES(4), .RST_CYCLES(4)) dut (
    .CLK(CLK), .reset(reset),
    .kernel1_n(k1n), .kernel2_n(k2n), .kernel3_n(k3n), .identity_n(idn),
    .frame_done(frame_done),
    .kernel(kernel), .identity_en(identity_en), .proc_rst(proc_rst),
    .sel_valid(sel_valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] lv);
    {idn, k3n, k2n, k1n} = lv;
  endtask

  // mask bits: {identity, k3, k2, k1}
  task automatic press(input logic [3:0] mask);
    drive(~mask);
    tick(10);
    drive(4'hF);
    tick(8);
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((busy || sb.size() != 0) && i < 80) begin
      tick(1);
      i++;
    end
    if (i >= 80) chk(tag, busy, 0);
    tick(2);
  endtask

  always @(negedge CLK) begin
    if (reset) begin
      prst_len = 0;
    end else begin
      if (proc_rst) prst_len++;
      else if (prst_len != 0) begin
        chk("prst_len", prst_len, 4);
        prst_len = 0;
      end
      if (sel_valid) begin
        sv_cnt++;
        chk("busy_at_sv", busy, 0);
        if (sb.size() == 0) chk("sv_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("sv_kernel", kernel, e[1:0]);
          chk("sv_ident", identity_en, e[2]);
        end
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_kernel", kernel, 0);
    chk("rst_ident", identity_en, 0);
    chk("rst_prst", proc_rst, 1);
    chk("rst_sv", sel_valid, 0);
    chk("rst_busy", busy, 1);

    sb.push_back(3'b000);
    reset = 1'b0;
    wait_idle("boot_timeout");
    chk("boot_kernel", kernel, 0);
    chk("boot_busy", busy, 0);
    chk("boot_sv", sv_cnt, 1);

    // frame_done while running is ignored
    pulse_frame();
    tick(3);
    chk("run_fd_busy", busy, 0);
    chk("run_fd_prst", proc_rst, 0);

    // pressing the current kernel does nothing
    s = sv_cnt;
    seen = 0;
    drive(4'b1110);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) drive(4'hF);
      tick(1);
      seen = seen | busy | proc_rst;
    end
    chk("same_k_busy", seen, 0);
    chk("same_k_sv", sv_cnt - s, 0);

    // bouncy kernel2 press
    s = sv_cnt;
    begin
      int pat[6] = '{1, 1, 2, 1, 3, 2};
      for (int i = 0; i < 6; i++) begin
        drive((i % 2) ? 4'hF : 4'b1101);
        tick(pat[i]);
      end
    end
    drive(4'b1101);
    tick(10);
    drive(4'hF);
    tick(8);
    chk("drain_busy", busy, 1);
    chk("drain_kernel", kernel, 0);
    chk("drain_prst", proc_rst, 0);
    tick(5);
    chk("drain_hold", busy, 1);
    sb.push_back(3'b001);
    pulse_frame();
    wait_idle("k2_timeout");
    chk("k2_sv", sv_cnt - s, 1);
    chk("k2_kernel", kernel, 1);

    // kernel1 and kernel3 together: kernel1 wins
    press(4'b0101);
    chk("k13_busy", busy, 1);
    sb.push_back(3'b000);
    pulse_frame();
    wait_idle("k13_timeout");
    chk("k13_kernel", kernel, 0);

    // kernel3 then kernel2 in drain; kernel1 arrives during restart
    s = sv_cnt;
    press(4'b0100);
    press(4'b0010);
    sb.push_back(3'b001);
    drive(4'b1110);
    tick(3);
    pulse_frame();
    tick(12);
    drive(4'hF);
    tick(8);
    wait_idle("k32_timeout");
    chk("k32_kernel", kernel, 1);
    chk("k32_sv", sv_cnt - s, 1);
    chk("k32_busy", busy, 0);

    // identity toggle
    press(4'b1000);
    chk("id_pending", identity_en, 0);
    chk("id_busy", busy, 1);
    sb.push_back(3'b101);
    pulse_frame();
    wait_idle("id_timeout");
    chk("id_on", identity_en, 1);

    // two identity presses cancel, but the restart still happens
    s = sv_cnt;
    press(4'b1000);
    press(4'b1000);
    chk("id2_busy", busy, 1);
    sb.push_back(3'b101);
    pulse_frame();
    wait_idle("id2_timeout");
    chk("id2_sv", sv_cnt - s, 1);
    chk("id2_ident", identity_en, 1);

    // reset in the middle of a drain discards the pending selection
    press(4'b1000);
    chk("rd_busy_pre", busy, 1);
    reset = 1'b1;
    tick(2);
    chk("rd_kernel", kernel, 0);
    chk("rd_ident", identity_en, 0);
    chk("rd_prst", proc_rst, 1);
    chk("rd_busy", busy, 1);
    sb.push_back(3'b000);
    reset = 1'b0;
    wait_idle("rd_timeout");
    chk("rd_kernel_post", kernel, 0);
    chk("rd_ident_post", identity_en, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kernel_select_ctrl.md
KERNEL_SELECT_CTRL -- requirements
Module: kernel_select_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized cycles needed to accept a button level change.
REQ-002 SHALL have parameter RST_CYCLES, default 4, meaning cycles proc_rst is held per restart.
REQ-003 SHALL have port CLK input 1: single clock, all flops rise on it.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have ports kernel1_n, kernel2_n, kernel3_n input 1 each: raw active-low kernel buttons, asynchronous to CLK.
REQ-006 SHALL have port identity_n input 1: raw active-low identity-toggle button.
REQ-007 SHALL have port frame_done input 1: one-cycle pulse marking end of displayed frame.
REQ-008 SHALL have port kernel output 2: selected kernel code for instruction memory.
REQ-009 SHALL have port identity_en output 1: identity (bypass) filter enable.
REQ-010 SHALL have port proc_rst output 1: active-high hold-reset for filter processor PC and datapath.
REQ-011 SHALL have port sel_valid output 1: one-cycle pulse when a new selection takes effect.
REQ-012 SHALL have port busy output 1: high whenever the FSM is not in RUN.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer.
REQ-014 SHALL update a button's debounced level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 SHALL generate a press event, one cycle wide, on a debounced 1->0 transition; releases generate nothing.
REQ-016 SHALL resolve simultaneous kernel press events by priority kernel1 > kernel2 > kernel3; codes are kernel1=00, kernel2=01, kernel3=10; 11 SHALL never be output.
REQ-017 SHALL use FSM states RUN, DRAIN, RESTART.
REQ-018 In RUN, the block SHALL latch a pending selection and enter DRAIN on a kernel press with code != current kernel, or on an identity press (pending identity = ~identity_en).
REQ-019 In RUN, a press of the already-selected kernel SHALL be ignored (no restart).
REQ-020 In DRAIN, the block SHALL overwrite the pending kernel with any new kernel press (latest wins) and toggle pending identity on each identity press.
REQ-021 In DRAIN, on frame_done, the block SHALL load kernel/identity_en from pending, assert proc_rst, clear the counter and enter RESTART in the same cycle.
REQ-022 In RESTART, proc_rst SHALL stay high exactly RST_CYCLES cycles; the FSM SHALL then enter RUN with proc_rst low and sel_valid high for that one cycle.
REQ-023 Presses arriving in RESTART SHALL be dropped.
REQ-024 frame_done in RUN or RESTART SHALL have no effect.
REQ-025 If DRAIN resolves to no change (pending equals current), it SHALL still restart per REQ-021.
REQ-026 Outputs kernel, identity_en, proc_rst, sel_valid and busy SHALL be registered.

Reset
REQ-027 While reset is high: kernel=00, identity_en=0, proc_rst=1, sel_valid=0, busy=1, synchronizers and debounced levels=1, counters=0, FSM=RESTART.
REQ-028 After reset deasserts, the block SHALL complete the RESTART sequence (RST_CYCLES of proc_rst, then sel_valid pulse) before reaching RUN.
REQ-029 Reset asserted mid-DRAIN or mid-RESTART SHALL discard the pending selection.

Structure
REQ-030 Package filter_gpu_pkg SHALL hold kernel_t (2-bit enum K1=00, K2=01, K3=10) and the FSM state enum.
REQ-031 Sub-module btn_debounce (synchronizer + counter + press-event output, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, RST_CYCLES=4)
REQ-032 Release reset -> proc_rst high 4 cycles, then sel_valid pulse, kernel=00, busy=0.
REQ-033 kernel2_n low with bounces of 1-3 cycles, then held low 10 cycles -> exactly one press event; DRAIN until frame_done; then kernel=01, proc_rst 4 cycles, one sel_valid.
REQ-034 kernel1_n and kernel3_n fall in the same cycle while kernel=01 -> kernel=00 after the next frame_done.
REQ-035 In DRAIN, press kernel3 then kernel2 before frame_done -> kernel=01; a kernel1 press during RESTART -> ignored, kernel stays 01.
REQ-036 Press kernel1 while kernel=00 in RUN -> busy stays 0, no proc_rst, no sel_valid.
REQ-037 Identity press, then reset asserted mid-DRAIN -> identity_en=0, kernel=00, reset sequence per REQ-032.
